// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan controller.
// Snapshots BCD digits once per frame, then drives one digit position per slot.
// A blank gap at the start of each slot prevents ghosting between positions.
// Leading zeros can be suppressed, and BCD is decoded to segment patterns.
// Ports:
//   clk, reset_n            clock and async active-low reset
//   digits_in[4*NUM_DIG]    BCD digits, [3:0] = digit 0 (least significant)
//   dp_in[NUM_DIG]          decimal point request per digit
//   blank_en                suppress leading zeros
//   freeze                  hold the snapshot (display hold)
//   dim[3] (option)         brightness reduction, 0 = full
//   seg_out[8]              {dp,g,f,e,d,c,b,a} at pin polarity
//   dig_sel[NUM_DIG]        one-hot digit enable at pin polarity
//   scan_tick, frame_done   end-of-slot / end-of-frame pulses
// Optional macro SEG_SCAN_DIM_EN adds the dim input and PWM dimming.
module seg_scan_ctrl #(
    parameter int NUM_DIG    = 6,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [4*NUM_DIG-1:0] digits_in,
    input  logic [NUM_DIG-1:0]   dp_in,
    input  logic                 blank_en,
    input  logic                 freeze,
`ifdef SEG_SCAN_DIM_EN
    input  logic [2:0]           dim,
`endif
    output logic [7:0]           seg_out,
    output logic [NUM_DIG-1:0]   dig_sel,
    output logic                 scan_tick,
    output logic                 frame_done
);

    // At least 3 bits so the dimming phase can be taken from the counter.
    localparam int CW = ($clog2(SCAN_DIV) < 3) ? 3 : $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIG);

    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLK     = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIG - 1);

    // XOR masks: inactive pin level, also used to flip polarity.
    localparam logic [7:0] SEG_OFF =
        (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIG-1:0] DIG_OFF =
        (ACTIVE_LOW != 0) ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};

    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [NUM_DIG-1:0][3:0]   sh_q, sh_d;
    logic [NUM_DIG-1:0]        dp_q, dp_d;
    logic [7:0]                seg_q, seg_d;
    logic [NUM_DIG-1:0]        dig_q, dig_d;

    logic                      tick;
    logic                      fdone;
    logic                      drive;
    logic                      dig_en;
    logic                      allz;
    logic [NUM_DIG-1:0]        lz;
    logic [6:0]                abcdefg;

    function automatic logic [6:0] dec7(input logic [3:0] b);
        logic [6:0] s;
        case (b)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign tick  = (cnt_q == CNT_MAX);
    assign fdone = tick && (idx_q == IDX_MAX);
    assign drive = (cnt_q >= BLK);

`ifdef SEG_SCAN_DIM_EN
    logic [2:0] ph3;
    assign ph3    = 3'(cnt_q - BLK);
    assign dig_en = drive && ({1'b0, ph3} < (4'd8 - {1'b0, dim}));
`else
    assign dig_en = drive;
`endif

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        dp_d    = dp_q;
        allz    = 1'b1;
        lz      = '0;
        abcdefg = 7'h00;

        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        // Single load point keeps rippling counters from tearing the frame.
        if (fdone && !freeze) begin
            sh_d = digits_in;
            dp_d = dp_in;
        end

        // A digit is a leading zero when it and all digits above are zero.
        for (int k = NUM_DIG - 1; k >= 0; k--) begin
            allz  = allz & (sh_q[k] == 4'd0);
            lz[k] = allz && (k != 0) && blank_en;
        end

        abcdefg = lz[idx_q] ? 7'h00 : dec7(sh_q[idx_q]);

        seg_d = drive ? ({dp_q[idx_q], abcdefg} ^ SEG_OFF) : SEG_OFF;
        dig_d = (dig_en ? (NUM_DIG'(1) << idx_q) : '0) ^ DIG_OFF;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            sh_q  <= '0;
            dp_q  <= '0;
            seg_q <= SEG_OFF;
            dig_q <= DIG_OFF;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            sh_q  <= sh_d;
            dp_q  <= dp_d;
            seg_q <= seg_d;
            dig_q <= dig_d;
        end
    end

    assign seg_out    = seg_q;
    assign dig_sel    = dig_q;
    assign scan_tick  = tick;
    assign frame_done = fdone;

endmodule
